cache_way_array: RTL

Parametrised multi-way cache storage array: NUM_WAYS banks of NUM_SETS entries of WIDTH bits, with per-way valid bits, byte-masked writes and a registered read of all ways in parallel. A built-in flush sequencer clears every valid bit, one set per cycle. It serves as the data/tag/valid store for set-associative L1 caches, replacing the single-way, bit-wide array.

---
 rtl/cache_way_array_if.sv | 31 +++
 rtl/cache_way_array.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cache_way_array_if.sv
// Bus bundle for cache_way_array: read/write/flush requests and registered read results.
interface cache_way_array_if #(
    parameter int unsigned S_INDEX  = 3,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_WAYS = 2
) ();
    logic                      read;
    logic [S_INDEX-1:0]        rindex;
    logic                      load;
    logic [S_INDEX-1:0]        windex;
    logic [NUM_WAYS-1:0]       wway;
    logic [WIDTH/8-1:0]        wmask;
    logic [WIDTH-1:0]          datain;
    logic                      flush;
    logic [NUM_WAYS*WIDTH-1:0] dataout;
    logic [NUM_WAYS-1:0]       valid_out;
    logic                      busy;
    logic                      flush_done;

    // Requester side
    modport master (
        output read, rindex, load, windex, wway, wmask, datain, flush,
        input  dataout, valid_out, busy, flush_done
    );

    // Storage array side
    modport slave (
        input  read, rindex, load, windex, wway, wmask, datain, flush,
        output dataout, valid_out, busy, flush_done
    );
endinterface

// File: rtl/cache_way_array.sv
// Multi-way cache storage array with per-way valid bits, byte-masked writes,
// parallel registered read of all ways and a one-set-per-cycle valid flush.
// Optional macro CACHE_ARRAY_BYPASS_EN forwards a same-index write into the read result.
module cache_way_array #(
    parameter int unsigned S_INDEX  = 3,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_WAYS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_way_array_if.slave bus
);
    localparam int unsigned NUM_SETS  = 2**S_INDEX;
    localparam int unsigned NUM_BYTES = WIDTH / 8;

    typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_e;

    state_e                    state_q, state_d;
    logic [S_INDEX-1:0]        cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      flush_done_q, flush_done_d;
    logic [NUM_WAYS*WIDTH-1:0] dataout_q, dataout_d;
    logic [NUM_WAYS-1:0]       valid_out_q, valid_out_d;
    logic [NUM_WAYS-1:0]       valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]       valid_d [NUM_SETS];
    logic [WIDTH-1:0]          data_q  [NUM_SETS][NUM_WAYS];
    logic [WIDTH-1:0]          data_d  [NUM_SETS][NUM_WAYS];
    logic                      accept_c, start_c, rd_en_c, wr_en_c;

    // Replace the bytes of old_v selected by mask with the matching bytes of new_v
    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0]     old_v,
                                                     input logic [WIDTH-1:0]     new_v,
                                                     input logic [NUM_BYTES-1:0] mask);
        logic [WIDTH-1:0] res;
        res = old_v;
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (mask[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    // Flush sequencer next state and request qualification
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = (state_q != FLUSH);
        start_c  = (state_q == IDLE) && bus.flush;
        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == S_INDEX'(NUM_SETS - 1)) state_d = DONE;
                else                                 cnt_d   = cnt_q + S_INDEX'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rd_en_c      = bus.read && accept_c;
        wr_en_c      = bus.load && accept_c && !start_c;  // flush start drops the load
        busy_d       = (state_d == FLUSH);
        flush_done_d = (state_d == DONE);
    end

    // Storage update: masked writes to selected ways, valid clear of the flushed set
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (wr_en_c && bus.wway[w]) begin
                data_d[bus.windex][w]  = merge_bytes(data_q[bus.windex][w], bus.datain, bus.wmask);
                valid_d[bus.windex][w] = 1'b1;
            end
        end
        if (state_q == FLUSH) valid_d[cnt_q] = '0;
    end

    // Read of all ways of the selected set; holds when no read is accepted
    always_comb begin
        dataout_d   = dataout_q;
        valid_out_d = valid_out_q;
        if (rd_en_c) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                dataout_d[w*WIDTH +: WIDTH] = data_q[bus.rindex][w];
                valid_out_d[w]              = valid_q[bus.rindex][w];
`ifdef CACHE_ARRAY_BYPASS_EN
                if (wr_en_c && bus.wway[w] && (bus.windex == bus.rindex)) begin
                    dataout_d[w*WIDTH +: WIDTH] = merge_bytes(data_q[bus.rindex][w], bus.datain, bus.wmask);
                    valid_out_d[w]              = 1'b1;
                end
`endif
            end
        end
    end

    // Control, valid and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b0;
            dataout_q    <= '0;
            valid_out_q  <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            flush_done_q <= flush_done_d;
            dataout_q    <= dataout_d;
            valid_out_q  <= valid_out_d;
            valid_q      <= valid_d;
        end
    end

    // Data storage is not reset
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign bus.dataout    = dataout_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.busy       = busy_q;
    assign bus.flush_done = flush_done_q;
endmodule
